hex_display_ctrl: RTL and testbench
===================================

# hex_display_ctrl

Arbitrated update controller for the board's seven-segment bank. Two requesters (e.g. note readout and volume/octave readout) submit a packed hex value plus a per-digit blank mask through a req/ack handshake. A round-robin arbiter grants one requester. A scan FSM then time-shares a single `hex_decoder` across all digits, one digit per cycle, into registered active-low segment outputs that drive the HEX pins directly.

## Interface
- `NUM_DIGITS`, 6: number of seven-segment digits driven (1..8)
- `clock`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high; clears the state listed under Timing
- `req0`, `req1`  in  1 each  update request from requester 0/1; held high until ack
- `data0`, `data1`  in  4*NUM_DIGITS each  packed nibbles, digit i = bits [4i+3:4i]; stable while req high
- `blank0`, `blank1`  in  NUM_DIGITS each  bit i = 1 forces digit i dark
- `ack0`, `ack1`  out  1 each  single-cycle pulse: requester's value fully written to outputs
- `busy`  out  1  high in any state other than IDLE
- `hex_out`  out  7*NUM_DIGITS  active-low segments, digit i = bits [7i+6:7i], bit 0 = segment a … bit 6 = segment g

## Operation
- Segment encoding is exactly that of `hex_decoder`: 0 → 7'b1000000, 8 → 7'b0000000, F → 7'b0001110; blank = 7'h7F (all segments off).
- FSM states:
  - IDLE: if any req, arbitrate → LATCH.
  - LATCH: copy the granted requester's data/blank into shadow registers, record grant id, clear digit counter → SCAN.
  - SCAN: drive shadow nibble[cnt] into the decoder; write decoder result, or 7'h7F if blank[cnt], into hex_out digit cnt; cnt++. Go to DONE after cnt == NUM_DIGITS-1, otherwise stay in SCAN.
  - DONE: pulse ack of the granted requester, advance the round-robin pointer → IDLE.
- Arbitration:
  - Only one requester asserting: it wins.
  - Both asserting: the requester indicated by the pointer wins.
  - The pointer moves to the non-granted requester after each grant.
  - Reset pointer = requester 0.
- Digits not yet reached in SCAN hold their previous value; an update is never partially reverted.
- Requester must drop req the cycle after its ack. If req is still high in IDLE, it is re-arbitrated as a new request.
- A req drop or data change after LATCH has no effect; the scan completes from the shadow copy and ack still pulses.
- Counter width = clog2(NUM_DIGITS) with a 1-bit floor. The counter never wraps past NUM_DIGITS-1.

## Timing
- Reset values:
  - hex_out = all digits 7'h7F
  - ack0 = ack1 = 0, busy = 0
  - state IDLE, pointer 0, shadow registers 0
- Reset asserted in any state returns to IDLE on the next edge. Digits already written are overwritten with blank, and no ack is issued.
- Latency, with req seen high in IDLE at edge 0:
  - LATCH at edge 1
  - digit i written at edge 2+i
  - ack high during the cycle after edge 2+NUM_DIGITS. For NUM_DIGITS=6 that is 8 cycles from req to ack.
- busy rises the cycle after req is seen and falls together with the ack cycle ending.
- The losing requester's req is seen no earlier than the IDLE cycle after DONE. With both held, grants alternate with a minimum spacing of NUM_DIGITS+3 cycles.
- ack0 and ack1 are never high together.

## Structure
- `hex_ctrl_defs.vh` holds:
  - FSM state encodings (IDLE, LATCH, SCAN, DONE)
  - `SEG_BLANK` = 7'h7F
  - requester id constants
- Sub-module: exactly one instance of the existing `hex_decoder`, fed from a nibble mux on the digit counter; no per-digit decoders.
- The round-robin arbiter is inline logic (two requesters), not a separate module.

## Test plan
- Reset → hex_out all 7'h7F, busy=0, ack0=ack1=0. Reset again mid-SCAN (after digit 2 written) → all blank next cycle, no ack.
- req0, data0=24'h012345, blank0=0 → ack0 at cycle 8; hex_out digits 0..5 = codes for 5,4,3,2,1,0, digit0 = 7'b0010010.
- req1, data1=24'hFFFFFF, blank1=6'b110000 → digits 4,5 = 7'h7F, digits 0..3 = 7'b0001110; only ack1 pulses.
- req0 and req1 raised together and held → grant order 0,1,0; acks spaced 9 cycles; final hex_out = data of the last grant.
- req0 drops and data0 changes during SCAN → hex_out reflects the latched value; ack0 still pulses once.
- Digit-write monitor during one update → exactly one digit changes per SCAN cycle, in order 0→5, with no change in IDLE/LATCH/DONE.

Source files
------------

// File: rtl/hex_display_ctrl_pkg.sv
// Shared definitions for the seven-segment update controller: FSM states,
// segment constants, requester ids and the digit-counter width helper.
package hex_display_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  // A single digit still needs a one-bit counter, so $clog2(1) = 0 is floored.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_decoder.sv
// Hex nibble to active-low seven-segment decoder (bit 0 = a ... bit 6 = g).
module hex_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Two-requester round-robin update controller for the seven-segment bank;
// one shared decoder is time-multiplexed across the digits by the scan FSM.
module hex_display_ctrl
  import hex_display_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req0,
  input  logic                      req1,
  input  logic [4*NUM_DIGITS-1:0]   data0,
  input  logic [4*NUM_DIGITS-1:0]   data1,
  input  logic [NUM_DIGITS-1:0]     blank0,
  input  logic [NUM_DIGITS-1:0]     blank1,
  output logic                      ack0,
  output logic                      ack1,
  output logic                      busy,
  output logic [7*NUM_DIGITS-1:0]   hex_out
);

  localparam int CNT_W = cnt_width(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  state_t                  state;
  state_t                  next_state;
  logic [CNT_W-1:0]        cnt;
  logic                    pointer;
  logic                    grant_id;
  logic                    arb_grant;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [3:0]              cur_nibble;
  logic                    cur_blank;
  logic [6:0]              cur_seg;

  // A lone requester always wins; on contention the pointer breaks the tie.
  always_comb begin
    arb_grant = REQ_ID0;
    if (req0 && req1) begin
      arb_grant = pointer;
    end else if (req1) begin
      arb_grant = REQ_ID1;
    end
  end

  always_comb begin
    cur_nibble = shadow_data[4*int'(cnt) +: 4];
    cur_blank  = shadow_blank[cnt];
  end

  hex_decoder u_decoder (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (req0 || req1) next_state = ST_LATCH;
      ST_LATCH: next_state = ST_SCAN;
      ST_SCAN:  if (cnt == LAST_CNT) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Requesters are only sampled up to LATCH; the scan runs from the shadow copy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      pointer      <= REQ_ID0;
      grant_id     <= REQ_ID0;
      shadow_data  <= '0;
      shadow_blank <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      hex_out      <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      state <= next_state;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) grant_id <= arb_grant;
        end
        ST_LATCH: begin
          shadow_data  <= (grant_id == REQ_ID1) ? data1 : data0;
          shadow_blank <= (grant_id == REQ_ID1) ? blank1 : blank0;
          cnt          <= '0;
        end
        ST_SCAN: begin
          hex_out[7*int'(cnt) +: 7] <= cur_blank ? SEG_BLANK : cur_seg;
          if (cnt != LAST_CNT) cnt <= cnt + CNT_W'(1);
        end
        ST_DONE: begin
          ack0    <= (grant_id == REQ_ID0);
          ack1    <= (grant_id == REQ_ID1);
          pointer <= ~grant_id;
        end
        default: ;
      endcase
    end
  end

  // Busy stretches through the ack cycle so it falls together with the ack.
  assign busy = (state != ST_IDLE) || ack0 || ack1;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: each update pushes its expected id and
// segment image, popped and compared when the matching ack appears.
module tb_hex_display_ctrl;

  localparam int ND = 6;

  logic            clock = 1'b0;
  logic            reset;
  logic            req0, req1;
  logic [4*ND-1:0] data0, data1;
  logic [ND-1:0]   blank0, blank1;
  logic            ack0, ack1, busy;
  logic [7*ND-1:0] hex_out;

  typedef struct {
    logic            id;
    logic [7*ND-1:0] hex;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  hex_display_ctrl #(.NUM_DIGITS(ND)) dut (
    .clock   (clock),
    .reset   (reset),
    .req0    (req0),
    .req1    (req1),
    .data0   (data0),
    .data1   (data1),
    .blank0  (blank0),
    .blank1  (blank1),
    .ack0    (ack0),
    .ack1    (ack1),
    .busy    (busy),
    .hex_out (hex_out)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [7*ND-1:0] expected_hex(input logic [4*ND-1:0] d, input logic [ND-1:0] b);
    logic [7*ND-1:0] r;
    for (int i = 0; i < ND; i++)
      r[7*i +: 7] = b[i] ? 7'h7F : seg_code(d[4*i +: 4]);
    return r;
  endfunction

  // Waits on negedges for an ack, bounded by budget; cycles counts negedges seen.
  task automatic wait_ack(input int budget, output int cycles, output logic a0, output logic a1);
    cycles = 0;
    a0 = 1'b0;
    a1 = 1'b0;
    while (cycles < budget && !a0 && !a1) begin
      @(negedge clock);
      cycles++;
      a0 = ack0;
      a1 = ack1;
    end
  endtask

  task automatic pop_expected(output exp_t e);
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.id = 1'bx;
      e.hex = 'x;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 0; req1 = 0; data0 = '0; data1 = '0; blank0 = '0; blank1 = '0;
    repeat (2) @(negedge clock);
    compared++;
    if (hex_out !== {ND{7'h7F}}) begin
      mismatched++;
      $display("[TB] FAIL reset_hex: got %h expected %h", hex_out, {ND{7'h7F}});
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    compared++;
    if ({ack0, ack1} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_ack: got %b expected 00", {ack0, ack1});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_req0();
    int cycles;
    logic a0, a1;
    exp_t e;
    data0 = 24'h012345; blank0 = '0; req0 = 1'b1;
    sb.push_back('{1'b0, expected_hex(24'h012345, 6'b000000)});
    @(negedge clock);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL single_busy_rise: got %b expected 1", busy);
    end
    wait_ack(20, cycles, a0, a1);
    cycles++;
    req0 = 1'b0;
    pop_expected(e);
    compared++;
    if ({a0, a1} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL single_ack: got ack0/ack1=%b%b expected 10", a0, a1);
    end
    compared++;
    if (cycles !== ND + 3) begin
      mismatched++;
      $display("[TB] FAIL single_latency: got %0d expected %0d", cycles, ND + 3);
    end
    compared++;
    if (hex_out !== e.hex) begin
      mismatched++;
      $display("[TB] FAIL single_hex: got %h expected %h", hex_out, e.hex);
    end
    compared++;
    if (hex_out[6:0] !== 7'b0010010) begin
      mismatched++;
      $display("[TB] FAIL single_digit0: got %b expected 0010010", hex_out[6:0]);
    end
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL single_busy_ack: got %b expected 1", busy);
    end
    @(negedge clock);
    compared++;
    if ({ack0, busy} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL single_after_ack: got ack0/busy=%b%b expected 00", ack0, busy);
    end
  endtask

  task automatic test_blank_req1();
    int cycles;
    logic a0, a1;
    exp_t e;
    data1 = 24'hFFFFFF; blank1 = 6'b110000; req1 = 1'b1;
    sb.push_back('{1'b1, expected_hex(24'hFFFFFF, 6'b110000)});
    wait_ack(20, cycles, a0, a1);
    req1 = 1'b0;
    pop_expected(e);
    compared++;
    if ({a0, a1} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL blank_ack: got ack0/ack1=%b%b expected 01", a0, a1);
    end
    compared++;
    if (hex_out !== e.hex) begin
      mismatched++;
      $display("[TB] FAIL blank_hex: got %h expected %h", hex_out, e.hex);
    end
    compared++;
    if (hex_out[41:28] !== {7'h7F, 7'h7F} || hex_out[6:0] !== 7'b0001110) begin
      mismatched++;
      $display("[TB] FAIL blank_digits: got %h expected 7f/7f high, 0e low", hex_out);
    end
    @(negedge clock);
  endtask

  task automatic test_both_held();
    int cycles;
    logic a0, a1;
    exp_t e;
    data0 = 24'hABCDEF; blank0 = '0;
    data1 = 24'h987654; blank1 = '0;
    req0 = 1'b1; req1 = 1'b1;
    sb.push_back('{1'b0, expected_hex(24'hABCDEF, 6'b0)});
    sb.push_back('{1'b1, expected_hex(24'h987654, 6'b0)});
    sb.push_back('{1'b0, expected_hex(24'hABCDEF, 6'b0)});
    for (int k = 0; k < 3; k++) begin
      wait_ack(30, cycles, a0, a1);
      if (k == 2) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      pop_expected(e);
      compared++;
      if ((a0 ^ a1) !== 1'b1 || a1 !== e.id) begin
        mismatched++;
        $display("[TB] FAIL both_grant%0d: got ack0/ack1=%b%b expected id %b", k, a0, a1, e.id);
      end
      compared++;
      if (cycles !== ND + 3) begin
        mismatched++;
        $display("[TB] FAIL both_spacing%0d: got %0d expected %0d", k, cycles, ND + 3);
      end
      compared++;
      if (hex_out !== e.hex) begin
        mismatched++;
        $display("[TB] FAIL both_hex%0d: got %h expected %h", k, hex_out, e.hex);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_req_drop();
    int cycles;
    int extra_acks;
    logic a0, a1;
    exp_t e;
    data0 = 24'h13579B; blank0 = 6'b000100; req0 = 1'b1;
    sb.push_back('{1'b0, expected_hex(24'h13579B, 6'b000100)});
    repeat (3) @(negedge clock);
    req0 = 1'b0; data0 = 24'h000000; blank0 = 6'b111111;
    wait_ack(20, cycles, a0, a1);
    pop_expected(e);
    compared++;
    if ({a0, a1} !== 2'b10 || cycles + 3 !== ND + 3) begin
      mismatched++;
      $display("[TB] FAIL drop_ack: got ack0/ack1=%b%b at %0d expected 10 at %0d", a0, a1, cycles + 3, ND + 3);
    end
    compared++;
    if (hex_out !== e.hex) begin
      mismatched++;
      $display("[TB] FAIL drop_hex: got %h expected %h", hex_out, e.hex);
    end
    extra_acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (ack0 || ack1) extra_acks++;
    end
    compared++;
    if (extra_acks !== 0) begin
      mismatched++;
      $display("[TB] FAIL drop_extra_ack: got %0d expected 0", extra_acks);
    end
  endtask

  task automatic test_scan_order();
    logic [7*ND-1:0] prev;
    logic [ND-1:0] changed, want;
    exp_t e;
    prev = hex_out;
    data1 = 24'h2468AC; blank1 = '0; req1 = 1'b1;
    sb.push_back('{1'b1, expected_hex(24'h2468AC, 6'b0)});
    for (int k = 1; k <= ND + 3; k++) begin
      @(negedge clock);
      for (int i = 0; i < ND; i++) changed[i] = (hex_out[7*i +: 7] !== prev[7*i +: 7]);
      want = '0;
      if (k >= 3 && k <= ND + 2) want[k-3] = 1'b1;
      compared++;
      if (changed !== want) begin
        mismatched++;
        $display("[TB] FAIL scan_cycle%0d: got changed=%b expected %b", k, changed, want);
      end
      prev = hex_out;
    end
    req1 = 1'b0;
    pop_expected(e);
    compared++;
    if ({ack0, ack1} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL scan_ack: got ack0/ack1=%b%b expected 01", ack0, ack1);
    end
    compared++;
    if (hex_out !== e.hex) begin
      mismatched++;
      $display("[TB] FAIL scan_hex: got %h expected %h", hex_out, e.hex);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_scan();
    int acks_seen;
    data0 = 24'h777777; blank0 = '0; req0 = 1'b1;
    repeat (5) @(negedge clock);
    compared++;
    if (hex_out[20:14] !== seg_code(4'h7) || hex_out[27:21] !== seg_code(4'h6)) begin
      mismatched++;
      $display("[TB] FAIL midscan_partial: got d2=%b d3=%b expected %b %b",
               hex_out[20:14], hex_out[27:21], seg_code(4'h7), seg_code(4'h6));
    end
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clock);
    compared++;
    if (hex_out !== {ND{7'h7F}} || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midscan_reset: got hex=%h busy=%b expected all 7f busy 0", hex_out, busy);
    end
    reset = 1'b0;
    acks_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (ack0 || ack1) acks_seen++;
    end
    compared++;
    if (acks_seen !== 0) begin
      mismatched++;
      $display("[TB] FAIL midscan_no_ack: got %0d expected 0", acks_seen);
    end
    compared++;
    if (sb.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_blank_req1();
    test_both_held();
    test_req_drop();
    test_scan_order();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
